// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared widths and control-level constants for the multi-port register file
//   Purpose: default bus widths carried over from the previous register file (RegBus/RegAddrBus)
//            and the active levels of reset, write enable and read enable.
//   Ports:   none (package).
package regfile_mp_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  localparam logic [RegBusW-1:0] ZeroWord = '0;

  localparam logic RstEnable   = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - per-register busy scoreboard with issue/writeback/flush and per-read-port lookup
//   Purpose: tracks registers with a pending writer; decode sets, writeback clears, flush clears all.
//   Option:  REGFILE_BYPASS_EN enables the write-clear term on the read lookup.
//   Ports:   i_clk, i_rst (async, active-low)
//            i_iss_en, i_iss_addr   issue: mark destination busy
//            i_flush                synchronous clear of every busy bit
//            i_we, i_waddr          writeback ports (packed addresses)
//            i_re, i_raddr          read ports (packed addresses)
//            o_rbusy                per-read-port busy flag (combinational)
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = RegAddrBusW,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_iss_en,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic                     i_flush,
  input  logic [NUM_WR-1:0]        i_we,
  input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
  input  logic [NUM_RD-1:0]        i_re,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD-1:0]        o_rbusy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Clear first, then set: an issue in the same cycle as a writeback of the
  // same register belongs to a newer instruction, so the register stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (i_we[i] == WriteEnable && i_waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))
          w_busy_nxt[r] = 1'b0;
      end
      if (i_iss_en && i_iss_addr == ADDR_W'(r))
        w_busy_nxt[r] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RstEnable)
      r_busy <= '0;
    else if (i_flush)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_rbusy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (i_rst != RstEnable && i_re[j] == ReadEnable && i_raddr[j*ADDR_W +: ADDR_W] != '0) begin
        // Addresses at or beyond NUM_REGS match no entry and read as not busy.
        for (int r = 1; r < NUM_REGS; r++) begin
          if (i_raddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))
            o_rbusy[j] = r_busy[r];
        end
`ifdef REGFILE_BYPASS_EN
        // A same-cycle write is forwarded to the reader, so it is not stalled.
        for (int i = 0; i < NUM_WR; i++) begin
          if (i_we[i] == WriteEnable && i_waddr[i*ADDR_W +: ADDR_W] == i_raddr[j*ADDR_W +: ADDR_W])
            o_rbusy[j] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with zero register and busy scoreboard
//   Purpose: NUM_RD read ports, NUM_WR write ports (highest port wins), hard-wired r0,
//            busy scoreboard for issued writers.
//   Option:  REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
//   Ports:   i_clk, i_rst (async, active-low)
//            i_we, i_waddr, i_wdata     write ports (packed, port i at [i*W +: W])
//            i_re, i_raddr, o_rdata     read ports (packed, data combinational)
//            o_rbusy                    busy flag of each read address (combinational)
//            i_iss_en, i_iss_addr       issue: mark destination busy
//            i_flush                    clear all busy bits
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RegBusW,
  parameter int ADDR_W   = RegAddrBusW,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_WR-1:0]        i_we,
  input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
  input  logic [NUM_WR*DATA_W-1:0] i_wdata,
  input  logic [NUM_RD-1:0]        i_re,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic [NUM_RD-1:0]        o_rbusy,
  input  logic                     i_iss_en,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic                     i_flush
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Per-register write strobe and winning data, shared by storage and bypass.
  logic              w_wsel [NUM_REGS];
  logic [DATA_W-1:0] w_wval [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_wsel[r] = 1'b0;
      w_wval[r] = '0;
      if (r != 0) begin
        // Later ports overwrite earlier ones, giving highest-index priority.
        for (int i = 0; i < NUM_WR; i++) begin
          if (i_we[i] == WriteEnable && i_waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
            w_wsel[r] = 1'b1;
            w_wval[r] = i_wdata[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RstEnable) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_regs[r] <= DATA_W'(ZeroWord);
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_wsel[r])
          r_regs[r] <= w_wval[r];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (i_rst != RstEnable && i_raddr[j*ADDR_W +: ADDR_W] != '0 && i_re[j] == ReadEnable) begin
        // Out-of-range addresses match no register and stay zero.
        for (int r = 1; r < NUM_REGS; r++) begin
          if (i_raddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
`ifdef REGFILE_BYPASS_EN
            o_rdata[j*DATA_W +: DATA_W] = w_wsel[r] ? w_wval[r] : r_regs[r];
`else
            o_rdata[j*DATA_W +: DATA_W] = r_regs[r];
`endif
          end
        end
      end
    end
  end

  regfile_sb #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_iss_en   (i_iss_en),
    .i_iss_addr (i_iss_addr),
    .i_flush    (i_flush),
    .i_we       (i_we),
    .i_waddr    (i_waddr),
    .i_re       (i_re),
    .i_raddr    (i_raddr),
    .o_rbusy    (o_rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (NUM_REGS=16, 4 read / 2 write ports)
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  we = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [3:0]  re = '0;
  logic [19:0] raddr = '0;
  logic [127:0] rdata;
  logic [3:0]  rbusy;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_re(re), .i_raddr(raddr), .o_rdata(rdata), .o_rbusy(rbusy),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush)
  );

  // Monitor: at each falling edge, compare everything expected for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[e.port*32 +: 32] !== e.data) begin
        errors++;
        $display("FAIL %s port%0d rdata got %h want %h", e.name, e.port, rdata[e.port*32 +: 32], e.data);
      end
      checks++;
      if (rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d rbusy got %b want %b", e.name, e.port, rbusy[e.port], e.busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    we = '0; re = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    re[p] = 1'b1;
    raddr[p*5 +: 5] = a;
  endtask

  task automatic expect_rd(input string n, input int p, input logic [31:0] d, input logic b);
    exp_t e;
    e.name = n; e.port = p; e.data = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset held: writes and an issue must not land; reads forced to zero.
    step();
    wr(0, 5'd5, 32'h5555_5555); wr(1, 5'd5, 32'h6666_6666);
    iss_en = 1'b1; iss_addr = 5'd5;
    for (int j = 0; j < 4; j++) begin rd(j, 5'd5); expect_rd("rst_hold", j, 32'h0, 1'b0); end

    step();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin rd(j, 5'd5); expect_rd("rst_release", j, 32'h0, 1'b0); end

    // Dual write to r3: port 1 wins.
    step();
    wr(0, 5'd3, 32'h1111_1111); wr(1, 5'd3, 32'h2222_2222);
    for (int j = 0; j < 4; j++) begin rd(j, 5'd3); expect_rd("dual_wr_same", j, BYP ? 32'h2222_2222 : 32'h0, 1'b0); end
    step();
    for (int j = 0; j < 4; j++) begin rd(j, 5'd3); expect_rd("dual_wr_next", j, 32'h2222_2222, 1'b0); end

    // Zero register: write and issue ignored.
    step();
    wr(0, 5'd0, 32'hDEAD_BEEF); iss_en = 1'b1; iss_addr = 5'd0;
    rd(0, 5'd0); expect_rd("r0_same", 0, 32'h0, 1'b0);
    step();
    rd(0, 5'd0); expect_rd("r0_next", 0, 32'h0, 1'b0);
    re[1] = 1'b1; raddr[9:5] = 5'd0; expect_rd("r0_next_p1", 1, 32'h0, 1'b0);

    // Scoreboard set then writeback clear.
    step();
    iss_en = 1'b1; iss_addr = 5'd7;
    rd(1, 5'd7); expect_rd("iss7_same", 1, 32'h0, 1'b0);
    step();
    rd(0, 5'd7); expect_rd("iss7_busy", 0, 32'h0, 1'b1);
    rd(3, 5'd7); expect_rd("iss7_busy", 3, 32'h0, 1'b1);
    step();
    wr(1, 5'd7, 32'hA5A5_A5A5);
    rd(0, 5'd7); expect_rd("wb7_same", 0, BYP ? 32'hA5A5_A5A5 : 32'h0, BYP ? 1'b0 : 1'b1);
    step();
    rd(0, 5'd7); expect_rd("wb7_after", 0, 32'hA5A5_A5A5, 1'b0);
    step();
    rd(2, 5'd7); expect_rd("wb7_after2", 2, 32'hA5A5_A5A5, 1'b0);

    // Simultaneous issue and writeback of r9: set wins; then flush.
    step();
    iss_en = 1'b1; iss_addr = 5'd9; wr(0, 5'd9, 32'h0000_0099);
    rd(2, 5'd9); expect_rd("setclr_same", 2, BYP ? 32'h0000_0099 : 32'h0, 1'b0);
    step();
    rd(2, 5'd9); expect_rd("setclr_next", 2, 32'h0000_0099, 1'b1);
    step();
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
    rd(2, 5'd9); expect_rd("flush_same", 2, 32'h0000_0099, 1'b1);
    step();
    rd(2, 5'd9);  expect_rd("flush_r9", 2, 32'h0000_0099, 1'b0);
    rd(1, 5'd10); expect_rd("flush_r10", 1, 32'h0, 1'b0);

    // Read-enable guard on r4, with r4 issued in the same cycle as its write.
    step();
    wr(0, 5'd4, 32'h0000_1234); iss_en = 1'b1; iss_addr = 5'd4;
    step();
    for (int j = 0; j < 4; j++) rd(j, 5'd4);
    re[2] = 1'b0;
    expect_rd("re_guard", 0, 32'h0000_1234, 1'b1);
    expect_rd("re_guard", 1, 32'h0000_1234, 1'b1);
    expect_rd("re_guard_off", 2, 32'h0, 1'b0);
    expect_rd("re_guard", 3, 32'h0000_1234, 1'b1);

    // Out-of-range r20 on a 16-entry file: write and issue ignored, no aliasing onto r4.
    step();
    wr(1, 5'd20, 32'h0000_2020); iss_en = 1'b1; iss_addr = 5'd20;
    rd(3, 5'd20); expect_rd("oor_same", 3, 32'h0, 1'b0);
    step();
    rd(3, 5'd20); expect_rd("oor_next", 3, 32'h0, 1'b0);
    rd(0, 5'd4);  expect_rd("oor_alias_r4", 0, 32'h0000_1234, 1'b1);

    // Asynchronous reset mid-operation clears storage and busy.
    step();
    #2 rst = 1'b0;
    rd(0, 5'd4); expect_rd("async_rst", 0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    rd(0, 5'd4); expect_rd("after_rst_r4", 0, 32'h0, 1'b0);
    rd(1, 5'd3); expect_rd("after_rst_r3", 1, 32'h0, 1'b0);

    @(negedge clk);
    #1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
